// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: word type, ALU opcodes and scheduler FSM states.
package alu_sched_pkg;

  localparam int unsigned WORD_W = 24;

  typedef logic [WORD_W-1:0] core_word_t;

  typedef enum logic [2:0] {
    ALU_OP_ADD  = 3'd0,
    ALU_OP_SUB  = 3'd1,
    ALU_OP_AND  = 3'd2,
    ALU_OP_OR   = 3'd3,
    ALU_OP_XOR  = 3'd4,
    ALU_OP_SH   = 3'd5,
    ALU_OP_MUL  = 3'd6,
    ALU_OP_PASS = 3'd7
  } alu_opcode_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } alu_sched_state_t;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr_i,
// wrapping modulo N. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N);

  int unsigned      j;
  logic [IdxW-1:0]  j_idx;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j     = (int'(ptr_i) + i) % N;
      j_idx = IdxW'(j);
      if (!found && req_i[j_idx]) begin
        found        = 1'b1;
        gnt_o[j_idx] = 1'b1;
        idx_o        = j_idx;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between N_REQ requesters.
// Optional ALU_SCHED_MUL_STALL_EN: MUL ops hold EXEC for MUL_CYCLES cycles.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic       [N_REQ-1:0]  req_valid,
  output logic       [N_REQ-1:0]  req_ready,
  input  alu_opcode_t [N_REQ-1:0] req_op,
  input  core_word_t [N_REQ-1:0]  req_a,
  input  core_word_t [N_REQ-1:0]  req_b,
  input  logic       [N_REQ-1:0]  req_shl,
  input  logic       [N_REQ-1:0]  req_sha,
  output logic       [N_REQ-1:0]  resp_valid,
  input  logic       [N_REQ-1:0]  resp_ready,
  output core_word_t              resp_data,
  output logic                    resp_carry,
  output core_word_t              alu_in1,
  output core_word_t              alu_in2,
  output alu_opcode_t             alu_op,
  output logic                    alu_shl,
  output logic                    alu_sha,
  input  core_word_t              alu_out,
  input  logic                    alu_carry
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  if (N_REQ < 2 || MUL_CYCLES < 1) begin : g_bad_params
    $error("alu_sched: N_REQ must be >= 2 and MUL_CYCLES >= 1");
  end

  alu_sched_state_t state_q, state_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  alu_opcode_t      op_q, op_d;
  core_word_t       a_q, a_d;
  core_word_t       b_q, b_d;
  logic             shl_q, shl_d;
  logic             sha_q, sha_d;
  core_word_t       resp_data_q, resp_data_d;
  logic             resp_carry_q, resp_carry_d;

  logic [N_REQ-1:0] gnt;
  logic [IdxW-1:0]  gnt_idx;
  logic             exec_done;

  rr_arbiter #(
    .N(N_REQ)
  ) u_arb (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );

`ifdef ALU_SCHED_MUL_STALL_EN
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [CntW-1:0] mul_cnt_q, mul_cnt_d;

  assign exec_done = (mul_cnt_q == '0);

  always_comb begin
    mul_cnt_d = mul_cnt_q;
    if (state_q == StIdle && |req_valid) begin
      mul_cnt_d = (req_op[gnt_idx] == ALU_OP_MUL) ? CntW'(MUL_CYCLES - 1) : '0;
    end else if (state_q == StExec && !exec_done) begin
      mul_cnt_d = mul_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_cnt_q <= '0;
    end else begin
      mul_cnt_q <= mul_cnt_d;
    end
  end
`else
  assign exec_done = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    shl_d        = shl_q;
    sha_d        = sha_q;
    resp_data_d  = resp_data_q;
    resp_carry_d = resp_carry_q;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          owner_d = gnt_idx;
          op_d    = req_op[gnt_idx];
          a_d     = req_a[gnt_idx];
          b_d     = req_b[gnt_idx];
          shl_d   = req_shl[gnt_idx];
          sha_d   = req_sha[gnt_idx];
          state_d = StExec;
        end
      end
      StExec: begin
        if (exec_done) begin
          resp_data_d  = alu_out;
          resp_carry_d = (op_q == ALU_OP_ADD) ? alu_carry : 1'b0;
          state_d      = StResp;
        end
      end
      StResp: begin
        // Only the owner's ready bit completes the handshake.
        if (resp_ready[owner_q]) begin
          rr_ptr_d = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (state_q == StIdle) begin
      req_ready = gnt;
    end
    if (state_q == StResp) begin
      resp_valid[owner_q] = 1'b1;
    end
  end

  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_op     = op_q;
  assign alu_shl    = shl_q;
  assign alu_sha    = sha_q;
  assign resp_data  = resp_data_q;
  assign resp_carry = resp_carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      op_q         <= ALU_OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      shl_q        <= 1'b0;
      sha_q        <= 1'b0;
      resp_data_q  <= '0;
      resp_carry_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      shl_q        <= shl_d;
      sha_q        <= sha_d;
      resp_data_q  <= resp_data_d;
      resp_carry_q <= resp_carry_d;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural ALU; honours ALU_SCHED_MUL_STALL_EN.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int unsigned N_REQ = 2;

  logic                    clk;
  logic                    rst_n;
  logic       [N_REQ-1:0]  req_valid;
  logic       [N_REQ-1:0]  req_ready;
  alu_opcode_t [N_REQ-1:0] req_op;
  core_word_t [N_REQ-1:0]  req_a;
  core_word_t [N_REQ-1:0]  req_b;
  logic       [N_REQ-1:0]  req_shl;
  logic       [N_REQ-1:0]  req_sha;
  logic       [N_REQ-1:0]  resp_valid;
  logic       [N_REQ-1:0]  resp_ready;
  core_word_t              resp_data;
  logic                    resp_carry;
  core_word_t              alu_in1;
  core_word_t              alu_in2;
  alu_opcode_t             alu_op;
  logic                    alu_shl;
  logic                    alu_sha;
  core_word_t              alu_out;
  logic                    alu_carry;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sched #(
    .N_REQ(N_REQ),
    .MUL_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .req_shl(req_shl),
    .req_sha(req_sha),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_carry(resp_carry),
    .alu_in1(alu_in1),
    .alu_in2(alu_in2),
    .alu_op(alu_op),
    .alu_shl(alu_shl),
    .alu_sha(alu_sha),
    .alu_out(alu_out),
    .alu_carry(alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU standing in for the real combinational unit.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_op)
      ALU_OP_ADD: {alu_carry, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      ALU_OP_SUB: alu_out = alu_in1 - alu_in2;
      ALU_OP_AND: alu_out = alu_in1 & alu_in2;
      ALU_OP_OR:  alu_out = alu_in1 | alu_in2;
      ALU_OP_XOR: alu_out = alu_in1 ^ alu_in2;
      ALU_OP_SH: begin
        if (alu_shl)      alu_out = alu_in1 << alu_in2;
        else if (alu_sha) alu_out = core_word_t'($signed(alu_in1) >>> alu_in2);
        else              alu_out = alu_in1 >> alu_in2;
      end
      ALU_OP_MUL: alu_out = core_word_t'(alu_in1 * alu_in2);
      default:    alu_out = alu_in1;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_req(input int idx, input alu_opcode_t op, input core_word_t a,
                         input core_word_t b, input logic shl, input logic sha);
    req_op[idx]  = op;
    req_a[idx]   = a;
    req_b[idx]   = b;
    req_shl[idx] = shl;
    req_sha[idx] = sha;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;
    logic [1:0] exp_rdy;
    int owner;

    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    for (int i = 0; i < N_REQ; i++) set_req(i, ALU_OP_ADD, '0, '0, 1'b0, 1'b0);
    nxt();
    nxt();
    rst_n = 1'b1;
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
    check_eq("rst_resp_data", 32'(resp_data), 32'h0);
    check_eq("rst_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));

    // ADD with carry out on requester 0 only.
    nxt();
    set_req(0, ALU_OP_ADD, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
    req_valid  = 2'b01;
    resp_ready = 2'b01;
    #1;
    check_eq("add_grant", 32'(req_ready), 32'h1);
    nxt();
    req_valid = 2'b00;
    #1;
    check_eq("add_exec_rdy", 32'(req_ready), 32'h0);
    check_eq("add_exec_vld", 32'(resp_valid), 32'h0);
    check_eq("add_alu_in1", 32'(alu_in1), 32'hFFFFFF);
    nxt();
    #1;
    check_eq("add_resp_vld", 32'(resp_valid), 32'h1);
    check_eq("add_resp_data", 32'(resp_data), 32'h000000);
    check_eq("add_resp_carry", 32'(resp_carry), 32'h1);
    nxt();
    #1;
    check_eq("add_done_vld", 32'(resp_valid), 32'h0);

    // Requester 1; ready only on the non-owner bit must be ignored.
    nxt();
    set_req(1, ALU_OP_ADD, 24'h000005, 24'h000006, 1'b0, 1'b0);
    req_valid  = 2'b10;
    resp_ready = 2'b01;
    #1;
    check_eq("nown_grant", 32'(req_ready), 32'h2);
    nxt();
    req_valid = 2'b00;
    nxt();
    #1;
    check_eq("nown_resp_vld", 32'(resp_valid), 32'h2);
    check_eq("nown_resp_data", 32'(resp_data), 32'h00000B);
    nxt();
    #1;
    check_eq("nown_still_vld", 32'(resp_valid), 32'h2);
    resp_ready = 2'b10;
    nxt();
    #1;
    check_eq("nown_done_vld", 32'(resp_valid), 32'h0);

    // Both requesters continuously valid: grants alternate every 3 cycles.
    for (int k = 0; k < 12; k++) begin
      nxt();
      if (k == 0) begin
        set_req(0, ALU_OP_SUB, 24'h000010, 24'h000003, 1'b0, 1'b0);
        set_req(1, ALU_OP_XOR, 24'hF0F0F0, 24'h0F0F0F, 1'b0, 1'b0);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
      end
      #1;
      owner   = (k / 3) % 2;
      exp_rdy = (k % 3 == 0) ? ((owner == 0) ? 2'b01 : 2'b10) : 2'b00;
      check_eq($sformatf("rr_rdy_%0d", k), 32'(req_ready), 32'(exp_rdy));
      if (k % 3 == 2) begin
        check_eq($sformatf("rr_vld_%0d", k), 32'(resp_valid), (owner == 0) ? 32'h1 : 32'h2);
        check_eq($sformatf("rr_data_%0d", k), 32'(resp_data),
                 (owner == 0) ? 32'h00000D : 32'hFFFFFF);
        check_eq($sformatf("rr_carry_%0d", k), 32'(resp_carry), 32'h0);
      end
    end
    nxt();
    req_valid = 2'b00;

    // Arithmetic right shift with a stalled response while req1 waits.
    nxt();
    set_req(0, ALU_OP_SH, 24'h800000, 24'h000004, 1'b0, 1'b1);
    set_req(1, ALU_OP_ADD, 24'h000001, 24'h000002, 1'b0, 1'b0);
    req_valid  = 2'b11;
    resp_ready = 2'b00;
    #1;
    check_eq("sh_grant", 32'(req_ready), 32'h1);
    nxt();
    #1;
    check_eq("sh_exec_rdy", 32'(req_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      nxt();
      #1;
      check_eq($sformatf("sh_stall_vld_%0d", k), 32'(resp_valid), 32'h1);
      check_eq($sformatf("sh_stall_data_%0d", k), 32'(resp_data), 32'hF80000);
      check_eq($sformatf("sh_stall_rdy_%0d", k), 32'(req_ready), 32'h0);
    end
    nxt();
    resp_ready = 2'b01;
    #1;
    check_eq("sh_hs_vld", 32'(resp_valid), 32'h1);
    nxt();
    resp_ready = 2'b00;
    #1;
    check_eq("sh_next_grant", 32'(req_ready), 32'h2);
    nxt();
    req_valid  = 2'b00;
    resp_ready = 2'b10;
    nxt();
    #1;
    check_eq("sh_r1_vld", 32'(resp_valid), 32'h2);
    check_eq("sh_r1_data", 32'(resp_data), 32'h000003);

    // MUL latency depends on the stall option.
`ifdef ALU_SCHED_MUL_STALL_EN
    exp_lat = 4;
`else
    exp_lat = 2;
`endif
    nxt();
    set_req(0, ALU_OP_MUL, 24'h000123, 24'h000010, 1'b0, 1'b0);
    req_valid  = 2'b01;
    resp_ready = 2'b01;
    #1;
    check_eq("mul_grant", 32'(req_ready), 32'h1);
    lat = 11;
    for (int k = 1; k <= 10; k++) begin
      nxt();
      req_valid = 2'b00;
      #1;
      if (resp_valid[0]) begin
        lat = k;
        break;
      end
    end
    check_eq("mul_latency", 32'(lat), 32'(exp_lat));
    check_eq("mul_data", 32'(resp_data), 32'h001230);

    // Reset during EXEC of a MUL on req1 drops it and clears the pointer.
    nxt();
    set_req(1, ALU_OP_MUL, 24'h000007, 24'h000009, 1'b0, 1'b0);
    req_valid  = 2'b10;
    resp_ready = 2'b00;
    #1;
    check_eq("rstx_grant", 32'(req_ready), 32'h2);
    nxt();
    req_valid = 2'b00;
    rst_n     = 1'b0;
    nxt();
    rst_n = 1'b1;
    #1;
    check_eq("rstx_vld", 32'(resp_valid), 32'h0);
    check_eq("rstx_data", 32'(resp_data), 32'h0);
    check_eq("rstx_carry", 32'(resp_carry), 32'h0);
    check_eq("rstx_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
    check_eq("rstx_alu_in1", 32'(alu_in1), 32'h0);
    check_eq("rstx_rdy_idle", 32'(req_ready), 32'h0);
    set_req(0, ALU_OP_ADD, 24'h000002, 24'h000003, 1'b0, 1'b0);
    set_req(1, ALU_OP_ADD, 24'h000004, 24'h000004, 1'b0, 1'b0);
    req_valid = 2'b11;
    #1;
    check_eq("rstx_ptr_grant", 32'(req_ready), 32'h1);
    nxt();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    #1;
    check_eq("rstx_no_resp", 32'(resp_valid), 32'h0);
    nxt();
    #1;
    check_eq("rstx_new_vld", 32'(resp_valid), 32'h1);
    check_eq("rstx_new_data", 32'(resp_data), 32'h000005);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
